// File: rtl/aes_pkg.sv
// Shared AES constants and the stream-state encoding for the round-key store.
package aes_pkg;

    localparam int unsigned AES_KEY_W      = 128;
    localparam int unsigned AES_NUM_ROUNDS = 10;
    localparam int unsigned AES_IDX_W      = 4;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_STREAM
    } stream_state_e;

endpackage

// File: rtl/aes_rk_mem.sv
// Round-key register file: one write port, one registered read port.
// Storage is not reset; only the read data register is.
module aes_rk_mem #(
    parameter int unsigned KEY_W    = 128,
    parameter int unsigned NUM_KEYS = 11,
    parameter int unsigned IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [KEY_W-1:0] wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [KEY_W-1:0] rdata
);

    logic [KEY_W-1:0] mem_q [NUM_KEYS];

    // Write port; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < NUM_KEYS)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when re is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re && (32'(raddr) < NUM_KEYS)) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/aes_round_key_store.sv
// Captures the AES-128 round-key schedule and streams it to the round core,
// ascending for encryption and descending for decryption.
module aes_round_key_store
    import aes_pkg::*;
#(
    parameter int unsigned KEY_W    = AES_KEY_W,
    parameter int unsigned NUM_KEYS = AES_NUM_ROUNDS + 1,
    parameter int unsigned IDX_W    = AES_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [KEY_W-1:0] wr_key,
    output logic             keys_ready,
    input  logic             start,
    input  logic             decrypt,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [IDX_W-1:0] rk_index,
    output logic [KEY_W-1:0] rk_key,
    output logic             rk_last,
    output logic             err_seq
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    stream_state_e    state_q, state_d;
    logic             dec_q, dec_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             keys_ready_q, keys_ready_d;
    logic [IDX_W-1:0] last_wr_q, last_wr_d;
    logic             loaded_q, loaded_d;
    logic             err_q, err_d;
    logic             wr_accept;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;

    aes_rk_mem #(
        .KEY_W    (KEY_W),
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wr_index),
        .wdata (wr_key),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rk_key)
    );

    // Write-sequence checker: only in-order (or repeated) indices are stored.
    always_comb begin
        wr_accept    = 1'b0;
        last_wr_d    = last_wr_q;
        loaded_d     = loaded_q;
        keys_ready_d = keys_ready_q;
        err_d        = err_q;
        if (wr_en) begin
            if (state_q == ST_STREAM) begin
                err_d = 1'b1;
            end else if (wr_index == '0) begin
                wr_accept    = 1'b1;
                last_wr_d    = '0;
                loaded_d     = 1'b1;
                keys_ready_d = 1'b0;
            end else if (loaded_q && (wr_index == last_wr_q)) begin
                wr_accept = 1'b1;
            end else if (loaded_q && (wr_index == last_wr_q + IDX_W'(1))
                         && (wr_index <= LAST_IDX)) begin
                wr_accept = 1'b1;
                last_wr_d = wr_index;
            end else begin
                err_d = 1'b1;
            end
            if (wr_accept && (wr_index == LAST_IDX)) begin
                keys_ready_d = 1'b1;
            end
        end
    end

    // Stream FSM; start is judged against the pre-write keys_ready.
    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        idx_d   = idx_q;
        last_d  = last_q;
        rd_en   = 1'b0;
        rd_addr = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start && keys_ready_q) begin
                    state_d = ST_STREAM;
                    dec_d   = decrypt;
                    idx_d   = decrypt ? LAST_IDX : '0;
                    last_d  = 1'b0;
                    rd_en   = 1'b1;
                    rd_addr = idx_d;
                end
            end
            ST_STREAM: begin
                if (rk_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        last_d  = 1'b0;
                    end else begin
                        idx_d   = dec_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
                        last_d  = dec_q ? (idx_d == '0) : (idx_d == LAST_IDX);
                        rd_en   = 1'b1;
                        rd_addr = idx_d;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dec_q        <= 1'b0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            keys_ready_q <= 1'b0;
            last_wr_q    <= '0;
            loaded_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dec_q        <= dec_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            keys_ready_q <= keys_ready_d;
            last_wr_q    <= last_wr_d;
            loaded_q     <= loaded_d;
            err_q        <= err_d;
        end
    end

    assign busy       = (state_q == ST_STREAM);
    assign rk_valid   = (state_q == ST_STREAM);
    assign rk_index   = idx_q;
    assign rk_last    = last_q;
    assign keys_ready = keys_ready_q;
    assign err_seq    = err_q;

endmodule

// File: tb/tb_aes_round_key_store.sv
// Randomised bench for aes_round_key_store against a transaction-level model.
module tb_aes_round_key_store;

    localparam int KW = 128;
    localparam int NK = 11;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_index = '0;
    logic [KW-1:0] wr_key = '0;
    logic          keys_ready;
    logic          start = 1'b0;
    logic          decrypt = 1'b0;
    logic          busy;
    logic          rk_valid;
    logic          rk_ready = 1'b0;
    logic [IW-1:0] rk_index;
    logic [KW-1:0] rk_key;
    logic          rk_last;
    logic          err_seq;

    aes_round_key_store dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_key     (wr_key),
        .keys_ready (keys_ready),
        .start      (start),
        .decrypt    (decrypt),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_index   (rk_index),
        .rk_key     (rk_key),
        .rk_last    (rk_last),
        .err_seq    (err_seq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the stored schedule plus the load bookkeeping.
    logic [KW-1:0] m_mem [NK];
    bit            m_ready  = 1'b0;
    bit            m_err    = 1'b0;
    bit            m_loaded = 1'b0;
    int            m_last   = 0;

    task automatic check(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_ready  = 1'b0;
        m_err    = 1'b0;
        m_loaded = 1'b0;
        m_last   = 0;
    endtask

    task automatic model_write(input int idx, input logic [KW-1:0] key);
        if (idx == 0) begin
            m_mem[0] = key;
            m_last   = 0;
            m_loaded = 1'b1;
            m_ready  = 1'b0;
        end else if (m_loaded && idx <= NK - 1 && (idx == m_last || idx == m_last + 1)) begin
            m_mem[idx] = key;
            m_last     = idx;
            if (idx == NK - 1) m_ready = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic write_key(input int idx, input logic [KW-1:0] key, input int hold);
        wr_en    = 1'b1;
        wr_index = IW'(idx);
        wr_key   = key;
        for (int c = 0; c < hold; c++) begin
            tick();
            model_write(idx, key);
            if (c == 0) begin
                check("keys_ready_after_wr", 128'(keys_ready), 128'(m_ready));
                check("err_seq_after_wr", 128'(err_seq), 128'(m_err));
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic load_all(input bit pattern, input int hold);
        for (int i = 0; i < NK; i++) begin
            write_key(i, pattern ? {16{8'(i)}} : rand_key(), hold);
        end
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,1,0...; mode 2: random ready.
    task automatic run_stream(input bit dec, input int mode, input bit inject_wr,
                              input bit simul_wr0);
        bit            exp_start;
        int            exp_idx[$];
        logic [KW-1:0] exp_key[$];
        int            cyc;
        int            k;
        bit            phase;
        bit            r;
        logic [KW-1:0] nk;
        exp_start = m_ready;
        for (int i = 0; i < NK; i++) begin
            exp_idx.push_back(dec ? NK - 1 - i : i);
            exp_key.push_back(m_mem[dec ? NK - 1 - i : i]);
        end
        nk      = rand_key();
        decrypt = dec;
        start   = 1'b1;
        if (simul_wr0) begin
            wr_en    = 1'b1;
            wr_index = '0;
            wr_key   = nk;
        end
        tick();
        start = 1'b0;
        if (simul_wr0) begin
            wr_en = 1'b0;
            model_write(0, nk);
        end
        check("busy_after_start", 128'(busy), 128'(exp_start));
        check("valid_after_start", 128'(rk_valid), 128'(exp_start));
        if (exp_start) begin
            cyc   = 0;
            k     = 0;
            phase = 1'b1;
            while (rk_valid && cyc < 100) begin
                case (mode)
                    0:       r = 1'b1;
                    1:       begin r = phase; phase = ~phase; end
                    default: r = 1'($urandom_range(0, 1));
                endcase
                rk_ready = r;
                check("busy_during_stream", 128'(busy), 128'(1));
                if (k < NK) begin
                    check("rk_index", 128'(rk_index), 128'(exp_idx[k]));
                    check("rk_key", rk_key, exp_key[k]);
                    check("rk_last", 128'(rk_last), 128'(k == NK - 1));
                end
                if (inject_wr && cyc == 2) begin
                    wr_en    = 1'b1;
                    wr_index = '0;
                    wr_key   = rand_key();
                end
                if (r) k++;
                tick();
                cyc++;
                if (inject_wr && cyc == 3) begin
                    wr_en = 1'b0;
                    m_err = 1'b1;
                end
            end
            rk_ready = 1'b0;
            check("stream_ends_in_budget", 128'(rk_valid), 128'(0));
            check("transfer_count", 128'(k), 128'(NK));
            check("busy_after_stream", 128'(busy), 128'(0));
            check("last_after_stream", 128'(rk_last), 128'(0));
            check("index_holds_final", 128'(rk_index), 128'(dec ? 0 : NK - 1));
            check("key_holds_final", rk_key, exp_key[NK-1]);
            if (mode == 0) check("cycles_ready_high", 128'(cyc), 128'(NK));
            if (mode == 1) check("cycles_ready_toggle", 128'(cyc), 128'(2 * NK - 1));
        end
        check("keys_ready_after_stream", 128'(keys_ready), 128'(m_ready));
        check("err_seq_after_stream", 128'(err_seq), 128'(m_err));
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        check("rst_keys_ready", 128'(keys_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_last", 128'(rk_last), 128'(0));
        check("rst_err", 128'(err_seq), 128'(0));
        check("rst_index", 128'(rk_index), 128'(0));
        check("rst_key", rk_key, 128'(0));

        // start with nothing loaded: ignored, no error
        run_stream(1'b0, 0, 1'b0, 1'b0);

        // patterned load, each index held 7 cycles, then both directions
        load_all(1'b1, 7);
        check("loaded_err_clear", 128'(err_seq), 128'(0));
        run_stream(1'b0, 0, 1'b0, 1'b0);
        run_stream(1'b1, 1, 1'b0, 1'b0);

        // boundary writes: rewrite 10 keeps ready, index past 10 is an error
        write_key(10, rand_key(), 2);
        check("rewrite_10_ready", 128'(keys_ready), 128'(1));
        check("rewrite_10_no_err", 128'(err_seq), 128'(0));
        write_key(11, rand_key(), 1);
        check("idx11_err", 128'(err_seq), 128'(1));
        check("idx11_ready_kept", 128'(keys_ready), 128'(1));
        run_stream(1'b0, 2, 1'b0, 1'b0);

        // out-of-order reload 0,1,3 then 2..10
        write_key(0, rand_key(), 2);
        write_key(1, rand_key(), 2);
        write_key(3, rand_key(), 2);
        check("ooo_ready_low", 128'(keys_ready), 128'(0));
        for (int i = 2; i < NK; i++) write_key(i, rand_key(), 1 + $urandom_range(0, 3));
        check("ooo_reload_ready", 128'(keys_ready), 128'(1));
        run_stream(1'b1, 2, 1'b0, 1'b0);

        // write during a stream is dropped
        run_stream(1'b0, 0, 1'b1, 1'b0);
        run_stream(1'b1, 0, 1'b0, 1'b0);

        // index-0 write alongside start: old schedule streams, ready drops after
        run_stream(1'b0, 2, 1'b0, 1'b1);
        run_stream(1'b0, 0, 1'b0, 1'b0);

        // reload, then reset on the 5th key of a stream
        load_all(1'b0, 1);
        decrypt  = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        rk_ready = 1'b1;
        repeat (4) tick();
        check("fifth_key_index", 128'(rk_index), 128'(4));
        check("fifth_key_value", rk_key, m_mem[4]);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        rk_ready = 1'b0;
        model_reset();
        check("midrst_valid", 128'(rk_valid), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_ready", 128'(keys_ready), 128'(0));
        check("midrst_err", 128'(err_seq), 128'(0));
        check("midrst_key", rk_key, 128'(0));
        run_stream(1'b0, 0, 1'b0, 1'b0);
        write_key(5, rand_key(), 1);
        load_all(1'b0, 1 + $urandom_range(0, 2));
        for (int t = 0; t < 4; t++) run_stream(1'($urandom_range(0, 1)), 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_key_store.md
Name: aes_round_key_store

Overview:
- Sits directly downstream of the round-index FSM and key-expansion datapath.
- Captures the 11 AES-128 round keys (indices 0..10) as they are produced.
- Raises keys_ready once the full schedule is held.
- On request, streams the keys to the cipher round core over a valid/ready handshake: ascending order for encryption, descending for decryption.

Parameters:
- KEY_W, 128, round key width in bits
- NUM_KEYS, 11, number of round keys (rounds 0..10)
- IDX_W, 4, width of round index fields

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe from key-expansion stage
- wr_index  in  IDX_W  round index of wr_key (0..10)
- wr_key  in  KEY_W  round key to store
- keys_ready  out  1  all 11 keys stored and consistent
- start  in  1  request a key stream
- decrypt  in  1  sampled with start; 1 = stream 10..0, 0 = stream 0..10
- busy  out  1  stream in progress
- rk_valid  out  1  rk_key/rk_index valid
- rk_ready  in  1  consumer accepts current key
- rk_index  out  IDX_W  index of presented key
- rk_key  out  KEY_W  presented round key
- rk_last  out  1  presented key is final of stream
- err_seq  out  1  sticky protocol error flag

Behaviour:
- Reset:
  - keys_ready, busy, rk_valid, rk_last, err_seq, rk_index, rk_key all 0.
  - last_wr pointer = 0, loaded = 0.
  - Key memory is not cleared.
- Write acceptance when not busy (wr_en=1):
  - wr_index==0: store slot 0, last_wr=0, loaded=1, keys_ready cleared. This starts a new schedule.
  - loaded && wr_index==last_wr: rewrite the same slot. Legal, because upstream holds the index for several cycles.
  - loaded && wr_index==last_wr+1: store the slot and advance last_wr.
  - Any other index, including >10: write ignored, err_seq set.
- keys_ready:
  - Set the cycle after slot 10 is written.
  - Remains 1 while index 10 is rewritten.
  - Cleared by a wr_index==0 write or by rst.
- Writes while busy: ignored entirely, err_seq set. Memory and keys_ready unchanged.
- Stream FSM:
  - States: IDLE, STREAM.
  - IDLE -> STREAM when start && keys_ready. decrypt is latched at that point.
  - start without keys_ready is ignored, with no error.
  - start while busy is ignored.
  - Latency: start sampled at edge N. At edge N+1, busy=1 and rk_valid=1 with the first key (index 0, or 10 if decrypt).
  - Handshake: a transfer occurs on a cycle with rk_valid && rk_ready. The next key is presented on the following edge, so 1 key/cycle is possible under continuous ready.
  - While rk_valid && !rk_ready, rk_key, rk_index and rk_last hold stable.
  - rk_last = 1 exactly when rk_index is 10 (encrypt) or 0 (decrypt).
  - On transfer of the last key: next edge rk_valid=0, rk_last=0, busy=0, FSM returns to IDLE. rk_key and rk_index hold their final values.
  - Back-to-back streams are allowed: start in the first IDLE cycle.
- Index arithmetic: IDX_W unsigned, no wrap.
  - Encrypt counts 0..10.
  - Decrypt counts 10..0.
  - The counter never steps past its terminal value.
- Reset mid-stream: the next cycle returns to the reset state. The consumer must discard the partial stream.
- Simultaneous wr_en and start in IDLE:
  - The write is processed.
  - start is evaluated against the pre-write keys_ready.
  - A wr_index==0 write and start in the same cycle therefore still starts a stream of the old schedule; the write clears keys_ready for future requests.
- err_seq clears only on rst.

Decomposition:
- Shared aes_pkg:
  - AES_KEY_W=128, AES_NUM_ROUNDS=10, AES_IDX_W=4.
  - Stream-state enum {ST_IDLE, ST_STREAM}.
- One natural sub-module: aes_rk_mem. It is an 11xKEY_W register file with one write port and one registered read port, and is reusable by the decrypt path.
- The write-sequence checker and stream FSM stay in the top level.

Test Plan:
- Load keys 0..10 with key i = {16{8'(i)}}, each index held for 7 cycles with wr_en=1 -> keys_ready=1 the cycle after the first index-10 write; err_seq=0.
- Encrypt stream, start with decrypt=0 and rk_ready tied 1 -> rk_valid for 11 consecutive cycles; rk_index 0..10; rk_key matches stored values; rk_last only on index 10; busy drops the following cycle.
- Decrypt stream with rk_ready toggling 1,0,1,0 -> indices 10..0 in order; outputs stable during ready=0; rk_last on index 0; 21 cycles total.
- Out-of-order load sequence 0,1,3 -> the write to 3 is ignored; err_seq=1; keys_ready stays 0; a later write to 2 is still accepted.
- wr_en during a stream -> write ignored; err_seq=1; the streamed keys are the old values.
- rst asserted on the 5th key of a stream -> next cycle rk_valid=0, busy=0, keys_ready=0; start is then ignored until a full reload.
